// File: rtl/uart_pkg.sv
// uart_pkg: shared types, register offsets and STATUS bit layout for the UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {UTIdle, UTStart, UTData, UTStop} UartTxState;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_CTRL   = 2'd2;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;

    function automatic logic [3:0] sat4(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through byte FIFO; a push into a full FIFO succeeds only alongside a pop.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with TX FIFO and STATUS readback.
// Define UART_TX_IRQ_EN to add the CTRL[0] irq enable and the TX-drained interrupt.
module uart_tx_io
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 48_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    UartTxState  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ovf_q, ovf_d;
    logic        irq_q, irq_d;
    logic [31:0] status, ctrl_val, rd_val;
    logic        wr, rd, push, pop, bit_done;
    logic [7:0]  f_dout;
    logic        f_full, f_empty;
    logic [AW:0] f_count;
    logic        unused;

    assign unused = ^{wdata[31:8], wmask[3:1]};
    assign wr     = sel & wmask[0];
    assign rd     = sel & rstrb;
    assign push   = wr & (addr == UART_REG_DATA);
    assign bit_done = cnt_q == CW'(DIV - 1);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        cnt_d   = (state_q == UTIdle || bit_done) ? '0 : cnt_q + CW'(1);
        case (state_q)
            UTIdle: if (!f_empty) begin
                pop     = 1'b1;
                shift_d = f_dout;
                state_d = UTStart;
            end
            UTStart: if (bit_done) begin
                bit_d   = 3'd0;
                state_d = UTData;
            end
            UTData: if (bit_done) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? UTStop : UTData;
            end
            UTStop: if (bit_done) state_d = UTIdle;
        endcase
        // tx is registered from the next state so it changes on the same edge as the state
        tx_d = (state_d == UTStart) ? 1'b0 : (state_d == UTData) ? shift_d[0] : 1'b1;
    end

    always_comb begin
        status                   = '0;
        status[ST_FULL]          = f_full;
        status[ST_EMPTY]         = f_empty;
        status[ST_BUSY]          = state_q != UTIdle;
        status[ST_OVF]           = ovf_q;
        status[ST_CNT_LO +: 4]   = sat4(32'(f_count));
        rd_val  = (addr == UART_REG_STATUS) ? status : (addr == UART_REG_CTRL) ? ctrl_val : '0;
        rdata_d = rd ? rd_val : rdata_q;
        // a push into a full FIFO is only lost when no pop frees a slot that cycle
        ovf_d   = (push & f_full & ~pop) | (ovf_q & ~(rd & addr == UART_REG_STATUS));
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_q, irq_en_d;

    always_comb begin
        irq_en_d = (wr & addr == UART_REG_CTRL) ? wdata[0] : irq_en_q;
        irq_d    = irq_en_d & f_empty & (state_q == UTIdle) & ~push;
        ctrl_val = {31'b0, irq_en_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_en_q <= 1'b0;
        else       irq_en_q <= irq_en_d;
    end
`else
    assign irq_d    = 1'b0;
    assign ctrl_val = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UTIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    assign tx    = tx_q;
    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: randomized and directed checks of the UART transmitter against a line-level receiver model.
module tb_uart_tx_io;
    localparam int DIV = 4;

    logic        clk = 1'b0, reset = 1'b1, sel = 1'b0, rstrb = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata;
    logic        tx, irq;

    int vectors = 0, miscompares = 0, cyc = 0, last_wr = 0;
    int idx = -1, hi_run = 0;
    logic s [40];
    logic [7:0] exp_q[$], rx_q[$];
    int gap_q[$];

    uart_tx_io #(.CLK_FREQ(48_000_000), .BAUD(12_000_000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wdata(wdata),
        .wmask(wmask), .rstrb(rstrb), .rdata(rdata), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // line receiver: 40 samples per frame, one per cycle, every bit must be steady for DIV samples
    initial begin
        logic ok;
        logic [7:0] bb;
        forever begin
            @(negedge clk);
            if (reset) begin
                idx = -1;
                hi_run = 0;
            end else if (idx < 0) begin
                if (tx === 1'b0) begin
                    gap_q.push_back(hi_run + DIV);
                    s[0] = 1'b0;
                    idx = 1;
                end else hi_run++;
            end else begin
                s[idx] = tx;
                idx++;
                if (idx == 40) begin
                    ok = (s[0] === 1'b0) && (s[36] === 1'b1);
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < DIV; j++)
                            if (s[DIV*k+j] !== s[DIV*k]) ok = 1'b0;
                    for (int i = 0; i < 8; i++) bb[i] = s[DIV + DIV*i];
                    chk("frame_fmt", 32'(ok), 32'd1);
                    rx_q.push_back(bb);
                    idx = -1;
                    hi_run = 0;
                end
            end
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wmask = 4'hF; addr = a; wdata = d;
        @(posedge clk);
        #1;
        last_wr = cyc;
        sel = 1'b0; wmask = 4'h0;
    endtask

    task automatic put(input logic [7:0] b, input bit accept);
        bus_wr(2'd0, {24'h0, b});
        if (accept) exp_q.push_back(b);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; rstrb = 1'b1; addr = a;
        @(posedge clk);
        #1;
        sel = 1'b0; rstrb = 1'b0;
        @(negedge clk);
        d = rdata;
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 3000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("rx_timeout", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0)
            chk(tag, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int n_edge, n0, len;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        bus_rd(2'd1, r);
        chk("status_reset", r, 32'h02);

        // single frame 0x55 with exact waveform and latency
        put(8'h55, 1'b1);
        @(negedge clk);
        chk("t1_pre_fall", 32'(tx), 32'd1);
        @(negedge clk);
        chk("t1_start", 32'(tx), 32'd0);
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            chk("t1_bit", 32'(tx), (k < DIV) ? 32'd0 : 32'((8'h55 >> (k / DIV - 1)) & 8'h1));
        end
        bus_rd(2'd1, r);
        chk("t1_busy", r, 32'h06);
        wait_rx(1);
        check_frames("t1_frame");
        repeat (2) @(posedge clk);
        bus_rd(2'd1, r);
        chk("t1_idle", r, 32'h02);
        bus_rd(2'd0, r);
        chk("data_read", r, 32'h0);
        bus_rd(2'd3, r);
        chk("rsvd_read", r, 32'h0);

        // back-to-back frames and inter-frame gap
        n0 = gap_q.size();
        put(8'hA5, 1'b1);
        put(8'h3C, 1'b1);
        wait_rx(2);
        chk("t2_gap", 32'(gap_q[n0 + 1]), 32'(DIV + 1));
        check_frames("t2_frame");

        // overflow: one frame in flight, nine more pushes into eight slots
        repeat (3) @(posedge clk);
        put(8'($urandom), 1'b1);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 9; i++) put(8'($urandom), i < 8);
        bus_rd(2'd1, r);
        chk("t3_status_ovf", r, 32'h8D);
        bus_rd(2'd1, r);
        chk("t3_ovf_clear", r, 32'h85);
        wait_rx(9);
        check_frames("t3_frame");

        // push coinciding with the pop of a full FIFO
        repeat (3) @(posedge clk);
        put(8'($urandom), 1'b1);
        n_edge = last_wr;
        for (int i = 0; i < 8; i++) put(8'($urandom), 1'b1);
        while (cyc < n_edge + 10 * DIV + 1) begin
            @(posedge clk);
            #1;
        end
        put(8'($urandom), 1'b1);
        bus_rd(2'd1, r);
        chk("t5_status", r, 32'h85);
        wait_rx(10);
        check_frames("t5_frame");

        // randomized bursts
        for (int rnd = 0; rnd < 3; rnd++) begin
            repeat (3) @(posedge clk);
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                put(8'($urandom), 1'b1);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            wait_rx(len);
            check_frames("rand_frame");
            repeat (2) @(posedge clk);
            bus_rd(2'd1, r);
            chk("rand_idle", r, 32'h02);
        end

        // reset in the middle of data bit 3 (bit 3 forced low)
        b = 8'($urandom) & 8'hF7;
        put(b, 1'b0);
        n_edge = last_wr;
        while (cyc < n_edge + 1 + DIV + 3 * DIV + 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t4_bit3_low", 32'(tx), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk("t4_tx_async", 32'(tx), 32'd1);
        chk("t4_rdata_async", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bus_rd(2'd1, r);
        chk("t4_status", r, 32'h02);
        repeat (80) @(posedge clk);
        chk("t4_no_frame", 32'(rx_q.size()), 32'd0);
        chk("t4_tx_idle", 32'(tx), 32'd1);

`ifdef UART_TX_IRQ_EN
        chk("t6_irq_off", 32'(irq), 32'd0);
        bus_wr(2'd2, 32'h1);
        @(negedge clk);
        chk("t6_irq_on", 32'(irq), 32'd1);
        bus_rd(2'd2, r);
        chk("t6_ctrl", r, 32'h1);
        put(8'($urandom), 1'b1);
        @(negedge clk);
        chk("t6_irq_push", 32'(irq), 32'd0);
        wait_rx(1);
        @(negedge clk);
        chk("t6_irq_stop", 32'(irq), 32'd0);
        @(negedge clk);
        chk("t6_irq_rise", 32'(irq), 32'd1);
        bus_wr(2'd2, 32'h0);
        @(negedge clk);
        chk("t6_irq_disable", 32'(irq), 32'd0);
        check_frames("t6_frame");
`else
        bus_wr(2'd2, 32'h1);
        bus_rd(2'd2, r);
        chk("t6_ctrl", r, 32'h0);
        chk("t6_irq_idle", 32'(irq), 32'd0);
        put(8'($urandom), 1'b1);
        repeat (10) @(posedge clk);
        chk("t6_irq_busy", 32'(irq), 32'd0);
        wait_rx(1);
        repeat (3) @(posedge clk);
        chk("t6_irq_drained", 32'(irq), 32'd0);
        check_frames("t6_frame");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
